// File: rtl/mw_writeback_stage.sv
// M/W pipeline register and write-back stage of the 5-stage MIPS core: load
// extension, write-back source select, register-file write port, retire counter.
module mw_writeback_stage #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m_valid,
  input  logic [31:0]         m_pc,
  input  logic                m_reg_we,
  input  logic [4:0]          m_rd,
  input  logic [1:0]          m_wb_sel,
  input  logic [31:0]         m_alu_res,
  input  logic [31:0]         m_mem_rdata,
  input  logic [2:0]          m_load_type,
  input  logic [31:0]         m_hilo,
  output logic [31:0]         grf_pc,
  output logic                grf_we,
  output logic [4:0]          grf_a3,
  output logic [31:0]         grf_wd,
  output logic                w_fwd_valid,
  output logic [RETIRE_W-1:0] retire_count
);

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_HILO = 2'd3;

  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  logic        w_valid;
  logic [31:0] w_pc;
  logic        w_reg_we;
  logic [4:0]  w_rd;
  logic [1:0]  w_wb_sel;
  logic [31:0] w_alu_res;
  logic [31:0] w_mem_rdata;
  logic [2:0]  w_load_type;
  logic [31:0] w_hilo;

  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid     <= 1'b0;
      w_pc        <= '0;
      w_reg_we    <= 1'b0;
      w_rd        <= '0;
      w_wb_sel    <= '0;
      w_alu_res   <= '0;
      w_mem_rdata <= '0;
      w_load_type <= '0;
      w_hilo      <= '0;
    end else begin
      w_valid     <= m_valid;
      w_pc        <= m_pc;
      w_reg_we    <= m_reg_we;
      w_rd        <= m_rd;
      w_wb_sel    <= m_wb_sel;
      w_alu_res   <= m_alu_res;
      w_mem_rdata <= m_mem_rdata;
      w_load_type <= m_load_type;
      w_hilo      <= m_hilo;
    end
  end

  // The instruction leaving W is counted; reset drops it uncounted.
  always_ff @(posedge clk) begin
    if (reset)
      retire_count <= '0;
    else if (w_valid)
      retire_count <= retire_count + RETIRE_W'(1);
  end

  assign off = w_alu_res[1:0];

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = off[1] ? w_mem_rdata[31:16] : w_mem_rdata[15:0];
    ld_data = w_mem_rdata;
    case (off)
      2'd0: ld_byte = w_mem_rdata[7:0];
      2'd1: ld_byte = w_mem_rdata[15:8];
      2'd2: ld_byte = w_mem_rdata[23:16];
      2'd3: ld_byte = w_mem_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    case (w_load_type)
      LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data = {24'h0, ld_byte};
      LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = w_mem_rdata;  // lw and unused encodings
    endcase
  end

  always_comb begin
    grf_wd = w_alu_res;
    case (w_wb_sel)
      WB_ALU:  grf_wd = w_alu_res;
      WB_MEM:  grf_wd = ld_data;
      WB_LINK: grf_wd = w_pc + 32'd8;
      WB_HILO: grf_wd = w_hilo;
      default: grf_wd = w_alu_res;
    endcase
  end

  assign grf_we      = w_valid & w_reg_we & (w_rd != 5'd0);
  assign grf_a3      = w_rd;
  assign grf_pc      = w_pc;
  assign w_fwd_valid = grf_we;

endmodule
